// File: rtl/segway_pkg.sv
// Shared types and A2D channel codes for the Segway control blocks.
package segway_pkg;

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} sched_state_t;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    // Maps the rotation pointer to its A2D channel; the unused code falls back to left.
    function automatic logic [2:0] chnl_of(input logic [1:0] ptr);
        case (ptr)
            2'd1:    return CH_RGHT;
            2'd2:    return CH_BATT;
            default: return CH_LFT;
        endcase
    endfunction

endpackage

// File: rtl/settle_tmr.sv
// Saturating settle timer with synchronous clear; flags when the terminal count is reached.
module settle_tmr #(
    parameter logic [25:0] TMR_FULL = 26'd65_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_tmr,
    output logic tmr_full
);

    logic [25:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr_tmr)
            count <= '0;
        else if (count < TMR_FULL)
            count <= count + 26'd1;
    end

    assign tmr_full = (count == TMR_FULL);

endmodule

// File: rtl/load_cell_a2d_sched.sv
// Round-robin A2D scheduler for the load cells and battery, plus the rider-weight
// and load-balance comparators and settle timer that feed steer_en_SM.
module load_cell_a2d_sched #(
    parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
    parameter logic [11:0] HYSTERESIS       = 12'h040,
    parameter logic [25:0] TMR_FULL         = 26'd65_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    input  logic        clr_tmr,
    output logic        tmr_full,
    output logic        sum_gt_min,
    output logic        sum_lt_min,
    output logic        diff_gt_eigth,
    output logic        diff_gt_15_16
);

    import segway_pkg::*;

    localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
    // Clamp the lower threshold at zero so a wide band cannot wrap around.
    localparam logic [12:0] THR_LO = (MIN_RIDER_WEIGHT > HYSTERESIS) ?
                                     ({1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS}) : 13'd0;

    sched_state_t state;
    logic [1:0]   ptr;
    logic [12:0]  sum;
    logic [11:0]  diff;
    logic         unused_rd;

    assign unused_rd = ^spi_rd[15:12];

    // Two SPI transactions per conversion: the first selects the channel, the second returns its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            spi_wrt   <= 1'b0;
            spi_cmd   <= 16'h0000;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            batt      <= 12'h000;
            cnv_cmplt <= 1'b0;
        end else begin
            spi_wrt   <= 1'b0;
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: if (nxt) begin
                    spi_wrt <= 1'b1;
                    spi_cmd <= {2'b00, chnl_of(ptr), 11'h000};
                    state   <= CMD;
                end
                CMD: if (spi_done) state <= GAP;
                GAP: begin
                    spi_wrt <= 1'b1;
                    state   <= READ;
                end
                READ: if (spi_done) begin
                    case (ptr)
                        2'd1:    rght_ld <= spi_rd[11:0];
                        2'd2:    batt    <= spi_rd[11:0];
                        default: lft_ld  <= spi_rd[11:0];
                    endcase
                    cnv_cmplt <= 1'b1;
                    ptr       <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);

    // Sum of zero at reset means no rider, hence sum_lt_min resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_gt_min    <= 1'b0;
            sum_lt_min    <= 1'b1;
            diff_gt_eigth <= 1'b0;
            diff_gt_15_16 <= 1'b0;
        end else begin
            sum_gt_min    <= (sum > THR_HI);
            sum_lt_min    <= (sum < THR_LO);
            diff_gt_eigth <= ({1'b0, diff} > (sum >> 3));
            diff_gt_15_16 <= ({1'b0, diff} > (sum - (sum >> 4)));
        end
    end

    settle_tmr #(.TMR_FULL(TMR_FULL)) u_settle_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_tmr  (clr_tmr),
        .tmr_full (tmr_full)
    );

endmodule

// File: tb/tb_load_cell_a2d_sched.sv
// Directed bench for load_cell_a2d_sched: an SPI responder, a per-cycle reference model
// built from the channel-rotation/comparator/timer rules, and literal spot checks.
module tb_load_cell_a2d_sched;

    localparam logic [25:0] TF    = 26'd100;
    localparam int          MIN_W = 'h200;
    localparam int          HYST  = 'h040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        nxt = 1'b0;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd = 16'h0000;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt;
    logic        clr_tmr = 1'b1;
    logic        tmr_full, sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    load_cell_a2d_sched #(
        .MIN_RIDER_WEIGHT(12'h200),
        .HYSTERESIS      (12'h040),
        .TMR_FULL        (TF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .nxt           (nxt),
        .spi_wrt       (spi_wrt),
        .spi_cmd       (spi_cmd),
        .spi_done      (spi_done),
        .spi_rd        (spi_rd),
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .batt          (batt),
        .cnv_cmplt     (cnv_cmplt),
        .clr_tmr       (clr_tmr),
        .tmr_full      (tmr_full),
        .sum_gt_min    (sum_gt_min),
        .sum_lt_min    (sum_lt_min),
        .diff_gt_eigth (diff_gt_eigth),
        .diff_gt_15_16 (diff_gt_15_16)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    endtask

    // SPI responder: answers each spi_wrt with spi_done four cycles later; the first
    // transaction of a conversion returns junk that must never be stored.
    logic [15:0] next_data = 16'h0000;
    int          resp_cnt = -1;
    int          txn_parity = 0;
    int          wrt_total = 0;
    logic [15:0] cmd_log[$];

    initial forever begin
        @(negedge clk);
        spi_done = 1'b0;
        if (!rst_n) begin
            resp_cnt   = -1;
            txn_parity = 0;
        end else begin
            if (resp_cnt == 0) begin
                spi_done = 1'b1;
                spi_rd   = (txn_parity == 1) ? 16'hF5A5 : next_data;
                resp_cnt = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end
            if (spi_wrt) begin
                wrt_total++;
                cmd_log.push_back(spi_cmd);
                txn_parity = (txn_parity == 1) ? 2 : 1;
                resp_cnt   = 3;
            end
        end
    end

    // Reference model, advanced on every rising edge from the inputs seen at that edge.
    int          chan_code[3] = '{0, 4, 5};
    int          m_ld[3];
    int          m_ch, m_dones, m_tcnt;
    int          edge_no = 0;
    int          m_wrt_at = -1;
    logic        m_busy, m_await;
    logic [15:0] m_cmd;
    logic        e_wrt, e_cmplt, e_gt, e_lt, e_e8, e_f16;

    initial forever begin
        logic        s_nxt, s_done, s_clr, s_rst;
        logic [15:0] s_rd;
        int          sum, d;
        @(posedge clk);
        edge_no++;
        s_nxt = nxt; s_done = spi_done; s_rd = spi_rd; s_clr = clr_tmr; s_rst = rst_n;
        e_wrt = 1'b0;
        e_cmplt = 1'b0;
        if (!s_rst) begin
            m_ld = '{0, 0, 0};
            m_ch = 0; m_busy = 1'b0; m_await = 1'b0; m_dones = 0;
            m_wrt_at = -1; m_cmd = 16'h0000; m_tcnt = 0;
        end
        sum   = m_ld[0] + m_ld[1];
        d     = (m_ld[0] > m_ld[1]) ? m_ld[0] - m_ld[1] : m_ld[1] - m_ld[0];
        e_gt  = sum > MIN_W + HYST;
        e_lt  = sum < MIN_W - HYST;
        e_e8  = d > sum / 8;
        e_f16 = d > sum - sum / 16;
        if (s_rst) begin
            if (!m_busy && s_nxt) begin
                m_busy = 1'b1; m_await = 1'b1; m_dones = 0; e_wrt = 1'b1;
                m_cmd = {2'b00, 3'(chan_code[m_ch]), 11'h000};
            end else if (m_busy && edge_no == m_wrt_at) begin
                e_wrt = 1'b1;
                m_await = 1'b1;
            end else if (m_busy && m_await && s_done) begin
                m_await = 1'b0;
                if (m_dones == 0) begin
                    m_dones = 1;
                    m_wrt_at = edge_no + 1;
                end else begin
                    m_ld[m_ch] = int'(s_rd[11:0]);
                    m_ch = (m_ch + 1) % 3;
                    e_cmplt = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (s_clr) m_tcnt = 0;
            else if (m_tcnt < int'(TF)) m_tcnt++;
        end
        #1;
        check_output("spi_wrt",       32'(spi_wrt),       32'(e_wrt));
        check_output("spi_cmd",       32'(spi_cmd),       32'(m_cmd));
        check_output("cnv_cmplt",     32'(cnv_cmplt),     32'(e_cmplt));
        check_output("lft_ld",        32'(lft_ld),        32'(m_ld[0]));
        check_output("rght_ld",       32'(rght_ld),       32'(m_ld[1]));
        check_output("batt",          32'(batt),          32'(m_ld[2]));
        check_output("sum_gt_min",    32'(sum_gt_min),    32'(e_gt));
        check_output("sum_lt_min",    32'(sum_lt_min),    32'(e_lt));
        check_output("diff_gt_eigth", 32'(diff_gt_eigth), 32'(e_e8));
        check_output("diff_gt_15_16", 32'(diff_gt_15_16), 32'(e_f16));
        check_output("tmr_full",      32'(tmr_full),      32'(m_tcnt == int'(TF)));
    end

    task automatic do_reset();
        @(negedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    // One conversion; optionally re-pulses nxt while busy, or raises nxt in the completion cycle.
    task automatic apply_stimulus(input logic [15:0] data, input logic extra_nxt, input logic nxt_at_done);
        logic seen;
        next_data = data;
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
        if (extra_nxt) begin
            @(negedge clk); nxt = 1'b1;
            @(negedge clk); nxt = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk); #1;
            if (spi_done && txn_parity == 2) seen = 1'b1;
        end
        check_output("conversion reaches second spi_done", 32'(seen), 32'h1);
        if (nxt_at_done) nxt = 1'b1;
        @(posedge clk); #1;
        check_output("cnv_cmplt after second spi_done", 32'(cnv_cmplt), 32'h1);
        @(negedge clk); nxt = 1'b0;
    endtask

    initial begin
        int w0, n;
        logic seen;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset spi_cmd",    32'(spi_cmd),    32'h0000);
        check_output("reset sum_lt_min", 32'(sum_lt_min), 32'h1);
        check_output("reset sum_gt_min", 32'(sum_gt_min), 32'h0);
        check_output("reset tmr_full",   32'(tmr_full),   32'h0);
        #1 rst_n = 1'b1;

        $display("[TB] basic conversion");
        w0 = wrt_total;
        cmd_log.delete();
        apply_stimulus(16'h0ABC, 1'b0, 1'b0);
        check_output("basic lft_ld", 32'(lft_ld), 32'h0ABC);
        check_output("basic spi_wrt pulses", 32'(wrt_total - w0), 32'd2);
        check_output("basic cmd 1", 32'(cmd_log[0]), 32'h0000);
        check_output("basic cmd 2", 32'(cmd_log[1]), 32'h0000);

        $display("[TB] rotation");
        do_reset();
        cmd_log.delete();
        apply_stimulus(16'h0130, 1'b0, 1'b0);
        apply_stimulus(16'h0130, 1'b1, 1'b0);
        apply_stimulus(16'h07EE, 1'b0, 1'b0);
        apply_stimulus(16'h0130, 1'b0, 1'b0);
        check_output("rotation spi_wrt pulses", 32'(cmd_log.size()), 32'd8);
        check_output("rotation cmd left",   32'(cmd_log[0]), 32'h0000);
        check_output("rotation cmd right",  32'(cmd_log[2]), 32'h2000);
        check_output("rotation cmd batt",   32'(cmd_log[4]), 32'h2800);
        check_output("rotation cmd wrap",   32'(cmd_log[6]), 32'h0000);
        settle();
        check_output("rotation batt", 32'(batt), 32'h07EE);
        check_output("sum 0x260 gt",  32'(sum_gt_min), 32'h1);
        check_output("sum 0x260 lt",  32'(sum_lt_min), 32'h0);

        $display("[TB] hysteresis and difference comparators");
        apply_stimulus(16'h00D0, 1'b0, 1'b0);
        settle();
        check_output("sum 0x200 gt", 32'(sum_gt_min), 32'h0);
        check_output("sum 0x200 lt", 32'(sum_lt_min), 32'h0);
        apply_stimulus(16'h0123, 1'b0, 1'b1);
        w0 = wrt_total;
        repeat (5) @(negedge clk);
        check_output("nxt with cnv_cmplt ignored", 32'(wrt_total - w0), 32'd0);
        apply_stimulus(16'h00E0, 1'b0, 1'b0);
        settle();
        check_output("sum 0x1B0 lt", 32'(sum_lt_min), 32'h1);
        apply_stimulus(16'h0100, 1'b0, 1'b0);
        apply_stimulus(16'h0456, 1'b0, 1'b0);
        apply_stimulus(16'h0200, 1'b0, 1'b0);
        settle();
        check_output("200/100 diff_gt_eigth", 32'(diff_gt_eigth), 32'h1);
        check_output("200/100 diff_gt_15_16", 32'(diff_gt_15_16), 32'h0);
        apply_stimulus(16'h0000, 1'b0, 1'b0);
        apply_stimulus(16'h0789, 1'b0, 1'b0);
        apply_stimulus(16'h0400, 1'b0, 1'b0);
        settle();
        check_output("400/000 diff_gt_eigth", 32'(diff_gt_eigth), 32'h1);
        check_output("400/000 diff_gt_15_16", 32'(diff_gt_15_16), 32'h1);

        $display("[TB] settle timer");
        @(negedge clk); clr_tmr = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (tmr_full) seen = 1'b1;
        end
        check_output("tmr_full latency", 32'(n), 32'd100);
        repeat (5) begin
            @(posedge clk); #1;
            check_output("tmr_full holds", 32'(tmr_full), 32'h1);
        end
        @(negedge clk); clr_tmr = 1'b1;
        @(posedge clk); #1;
        check_output("tmr_full drops after clr", 32'(tmr_full), 32'h0);
        @(negedge clk); clr_tmr = 1'b0;

        $display("[TB] reset during READ");
        do_reset();
        next_data = 16'h0999;
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk); #1;
            if (txn_parity == 2) seen = 1'b1;
        end
        check_output("second spi_wrt before reset", 32'(seen), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_output("aborted lft_ld", 32'(lft_ld), 32'h000);
        check_output("aborted spi_cmd", 32'(spi_cmd), 32'h0000);
        apply_stimulus(16'h0055, 1'b0, 1'b0);
        check_output("post-abort lft_ld", 32'(lft_ld), 32'h055);
        check_output("post-abort cmd", 32'(cmd_log[cmd_log.size() - 1]), 32'h0000);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
